// File: rtl/maindec_mc.sv
// Multicycle main decoder for an ARMv8-subset datapath.
// Six-state FSM with data-memory timeout and interrupt entry.
module maindec_mc #(
   parameter int MEM_TIMEOUT = 15,
   parameter bit IRQ_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] Op,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        irq,
   output logic        Reg2Loc,
   output logic        ALUSrc,
   output logic        MemtoReg,
   output logic        RegWrite,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [1:0]  Branch,
   output logic [1:0]  ALUOp,
   output logic        IMemReq,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        ERet,
   output logic        NotAnInstr,
   output logic        ExcTaken,
   output logic [3:0]  ExcCode,
   output logic        busy
);

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB, EXC
   } state_t;

   typedef enum logic [2:0] {
      C_UND, C_R, C_LDUR, C_STUR, C_CBZ, C_ERET, C_MRS, C_BR
   } cls_t;

   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

   state_t     state, state_nx;
   cls_t       cls, op_cls;
   logic [7:0] cnt, cnt_nx, cnt_inc;
   logic [3:0] cause, cause_nx;
   logic       fetch_entry;

   always_comb begin
      op_cls = C_UND;
      casez (Op)
         11'b1?001011000,
         11'b10?01010000: op_cls = C_R;
         11'b11111000010: op_cls = C_LDUR;
         11'b11111000000: op_cls = C_STUR;
         11'b10110100???: op_cls = C_CBZ;
         11'b11010110100: op_cls = C_ERET;
         11'b11010101001: op_cls = C_MRS;
         11'b11010110000: op_cls = C_BR;
         default:         op_cls = C_UND;
      endcase
   end

   // saturating so a huge timeout can never wrap the count
   assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         cls         <= C_UND;
         cnt         <= '0;
         cause       <= '0;
         fetch_entry <= 1'b1;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         cause       <= cause_nx;
         fetch_entry <= (state != FETCH);
         if (state == DECODE) cls <= op_cls;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      cause_nx   = cause;
      Reg2Loc    = 1'b0;
      ALUSrc     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Branch     = 2'b00;
      ALUOp      = 2'b00;
      IMemReq    = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      ERet       = 1'b0;
      NotAnInstr = 1'b0;
      ExcTaken   = 1'b0;
      ExcCode    = 4'b0000;
      busy       = (state != FETCH);
      unique case (state)
         FETCH: begin
            if (fetch_entry && irq && IRQ_EN) begin
               state_nx = EXC;
               cause_nx = 4'b0100;
            end else begin
               IMemReq = 1'b1;
               if (imem_ready) begin
                  IRWrite  = 1'b1;
                  PCWrite  = 1'b1;
                  state_nx = DECODE;
               end
            end
         end
         DECODE: begin
            if (op_cls == C_UND) begin
               NotAnInstr = 1'b1;
               state_nx   = EXC;
               cause_nx   = 4'b0001;
            end else begin
               state_nx = EXEC;
            end
         end
         EXEC: begin
            state_nx = FETCH;
            unique case (cls)
               C_R: begin
                  ALUOp    = 2'b10;
                  state_nx = WB;
               end
               C_LDUR: begin
                  ALUSrc   = 1'b1;
                  state_nx = MEM;
               end
               C_STUR: begin
                  ALUSrc   = 1'b1;
                  Reg2Loc  = 1'b1;
                  state_nx = MEM;
               end
               C_CBZ: begin
                  Reg2Loc = 1'b1;
                  ALUOp   = 2'b01;
                  Branch  = 2'b01;
                  PCWrite = 1'b1;
               end
               C_MRS: begin
                  ALUSrc   = 1'b1;
                  Reg2Loc  = 1'b1;
                  ALUOp    = 2'b01;
                  state_nx = WB;
               end
               C_ERET: begin
                  ALUOp   = 2'b01;
                  Branch  = 2'b01;
                  ERet    = 1'b1;
                  PCWrite = 1'b1;
               end
               C_BR: begin
                  ALUOp   = 2'b01;
                  Branch  = 2'b10;
                  PCWrite = 1'b1;
               end
               C_UND: state_nx = FETCH;
            endcase
            if (state_nx == MEM) cnt_nx = '0;
         end
         MEM: begin
            MemRead  = (cls == C_LDUR);
            MemWrite = (cls == C_STUR);
            // ready on the final allowed cycle still completes the access
            if (dmem_ready) begin
               state_nx = (cls == C_LDUR) ? WB : FETCH;
            end else if (cnt_inc >= TMO) begin
               cnt_nx   = cnt_inc;
               state_nx = EXC;
               cause_nx = 4'b0010;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         WB: begin
            RegWrite = 1'b1;
            MemtoReg = (cls == C_LDUR);
            state_nx = FETCH;
         end
         EXC: begin
            ExcTaken = 1'b1;
            ExcCode  = cause;
            PCWrite  = 1'b1;
            Branch   = 2'b11;
            state_nx = FETCH;
         end
         default: state_nx = FETCH;
      endcase
      if (!reset) begin
         Reg2Loc    = 1'b0;
         ALUSrc     = 1'b0;
         MemtoReg   = 1'b0;
         RegWrite   = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         Branch     = 2'b00;
         ALUOp      = 2'b00;
         IMemReq    = 1'b0;
         IRWrite    = 1'b0;
         PCWrite    = 1'b0;
         ERet       = 1'b0;
         NotAnInstr = 1'b0;
         ExcTaken   = 1'b0;
         ExcCode    = 4'b0000;
         busy       = 1'b0;
      end
   end

endmodule

// File: tb/tb_maindec_mc.sv
// Scoreboard bench for maindec_mc: per-instruction expected traces
// are queued by the driver and compared by an independent monitor.
module tb_maindec_mc;

   localparam int TMO_A = 4;
   localparam int TMO_B = 15;
   localparam int K_UND = 0, K_R = 1, K_LD = 2, K_ST = 3;
   localparam int K_CBZ = 4, K_ERET = 5, K_MRS = 6, K_BR = 7;

   typedef struct packed {
      logic       reg2loc, alusrc, memtoreg, regwrite, memread, memwrite;
      logic [1:0] branch, aluop;
      logic       imemreq, irwrite, pcwrite, eret, notaninstr, exctaken;
      logic [3:0] exccode;
      logic       busy;
   } out_t;

   typedef struct {
      out_t v;
      out_t m;
      int   tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, sel;
   logic [10:0] op;
   logic        imem_ready, dmem_ready, irq;
   wire  [20:0] va, vb;
   out_t        obs;
   exp_t        q[$];
   int          n_cmp, n_bad, tag;

   always #5 clk = ~clk;

   maindec_mc #(.MEM_TIMEOUT(TMO_A), .IRQ_EN(1'b1)) dut_a (
      .clk(clk), .reset(rst_a), .Op(op), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .irq(irq),
      .Reg2Loc(va[20]), .ALUSrc(va[19]), .MemtoReg(va[18]),
      .RegWrite(va[17]), .MemRead(va[16]), .MemWrite(va[15]),
      .Branch(va[14:13]), .ALUOp(va[12:11]), .IMemReq(va[10]),
      .IRWrite(va[9]), .PCWrite(va[8]), .ERet(va[7]),
      .NotAnInstr(va[6]), .ExcTaken(va[5]), .ExcCode(va[4:1]),
      .busy(va[0])
   );

   maindec_mc #(.MEM_TIMEOUT(TMO_B), .IRQ_EN(1'b0)) dut_b (
      .clk(clk), .reset(rst_b), .Op(op), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .irq(irq),
      .Reg2Loc(vb[20]), .ALUSrc(vb[19]), .MemtoReg(vb[18]),
      .RegWrite(vb[17]), .MemRead(vb[16]), .MemWrite(vb[15]),
      .Branch(vb[14:13]), .ALUOp(vb[12:11]), .IMemReq(vb[10]),
      .IRWrite(vb[9]), .PCWrite(vb[8]), .ERet(vb[7]),
      .NotAnInstr(vb[6]), .ExcTaken(vb[5]), .ExcCode(vb[4:1]),
      .busy(vb[0])
   );

   always_comb obs = out_t'(sel ? vb : va);

   // monitor
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         n_cmp++;
         if (((obs ^ e.v) & e.m) !== '0) begin
            n_bad++;
            $display("FAIL outputs tag=%0d got=%h exp=%h mask=%h",
                     e.tag, obs, e.v, e.m);
         end
      end
   end

   function automatic int classify(input logic [10:0] o);
      if (o ==? 11'b1?001011000 || o ==? 11'b10?01010000) return K_R;
      if (o == 11'b11111000010) return K_LD;
      if (o == 11'b11111000000) return K_ST;
      if (o ==? 11'b10110100???) return K_CBZ;
      if (o == 11'b11010110100) return K_ERET;
      if (o == 11'b11010101001) return K_MRS;
      if (o == 11'b11010110000) return K_BR;
      return K_UND;
   endfunction

   function automatic logic [10:0] gen_op(input int k);
      logic [10:0] o;
      o = '0;
      case (k)
         K_R: case ($urandom_range(0, 3))
            0: o = 11'b10001011000;
            1: o = 11'b11001011000;
            2: o = 11'b10001010000;
            default: o = 11'b10101010000;
         endcase
         K_LD:   o = 11'b11111000010;
         K_ST:   o = 11'b11111000000;
         K_CBZ:  o = {8'b10110100, 3'($urandom)};
         K_ERET: o = 11'b11010110100;
         K_MRS:  o = 11'b11010101001;
         K_BR:   o = 11'b11010110000;
         default: begin
            for (int i = 0; i < 20; i++) begin
               o = 11'($urandom);
               if (classify(o) == K_UND) break;
               o = '0;
            end
         end
      endcase
      return o;
   endfunction

   function automatic out_t exc(input logic [3:0] code);
      out_t e;
      e = '0;
      e.busy = 1'b1;
      e.exctaken = 1'b1;
      e.exccode = code;
      e.pcwrite = 1'b1;
      e.branch = 2'b11;
      return e;
   endfunction

   task automatic stepm(input out_t e, input out_t m);
      exp_t x;
      x.v = e;
      x.m = m;
      x.tag = tag;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input out_t e);
      stepm(e, '1);
   endtask

   // one instruction from FETCH entry back to the next FETCH entry
   task automatic run(input logic [10:0] o, input int fdel,
                      input int mdel, input bit irq0, input bit abort_mem);
      out_t e, m;
      int   c, tmo;
      bit   ien, rdy;
      c = classify(o);
      tmo = sel ? TMO_B : TMO_A;
      ien = !sel;
      op = o;
      dmem_ready = 1'($urandom);
      irq = irq0;
      if (irq0 && ien) begin
         imem_ready = 1'($urandom);
         e = '0;
         step(e);
         irq = 1'($urandom);
         step(exc(4'b0100));
         return;
      end
      for (int i = 0; i < fdel; i++) begin
         imem_ready = 1'b0;
         e = '0;
         e.imemreq = 1'b1;
         step(e);
         irq = 1'($urandom);
      end
      imem_ready = 1'b1;
      e = '0;
      e.imemreq = 1'b1;
      e.irwrite = 1'b1;
      e.pcwrite = 1'b1;
      step(e);
      imem_ready = 1'($urandom);
      irq = 1'($urandom);
      e = '0;
      e.busy = 1'b1;
      e.notaninstr = (c == K_UND);
      step(e);
      op = 11'($urandom);
      if (c == K_UND) begin
         step(exc(4'b0001));
         return;
      end
      e = '0;
      e.busy = 1'b1;
      m = '1;
      case (c)
         K_R:   e.aluop = 2'b10;
         K_LD:  e.alusrc = 1'b1;
         K_ST:  begin e.alusrc = 1'b1; e.reg2loc = 1'b1; end
         K_CBZ: begin
            e.reg2loc = 1'b1; e.aluop = 2'b01;
            e.branch = 2'b01; e.pcwrite = 1'b1;
         end
         K_MRS: begin
            e.alusrc = 1'b1; e.reg2loc = 1'b1; e.aluop = 2'b01;
         end
         K_ERET: begin
            e.aluop = 2'b01; e.branch = 2'b01;
            e.eret = 1'b1; e.pcwrite = 1'b1;
         end
         default: begin
            e.aluop = 2'b01; e.branch = 2'b10; e.pcwrite = 1'b1;
            m.reg2loc = 1'b0; m.alusrc = 1'b0;
         end
      endcase
      stepm(e, m);
      if (c == K_CBZ || c == K_BR || c == K_ERET) return;
      if (c == K_LD || c == K_ST) begin
         rdy = 1'b0;
         for (int k = 1; k <= tmo; k++) begin
            rdy = (k > mdel);
            dmem_ready = rdy;
            e = '0;
            e.busy = 1'b1;
            e.memread = (c == K_LD);
            e.memwrite = (c == K_ST);
            step(e);
            if (abort_mem) return;
            if (rdy) break;
         end
         dmem_ready = 1'($urandom);
         if (!rdy) begin
            step(exc(4'b0010));
            return;
         end
         if (c == K_ST) return;
      end
      e = '0;
      e.busy = 1'b1;
      e.regwrite = 1'b1;
      e.memtoreg = (c == K_LD);
      step(e);
   endtask

   task automatic rand_runs(input int n);
      int tmo;
      tmo = sel ? TMO_B : TMO_A;
      for (int i = 0; i < n; i++) begin
         tag++;
         run(gen_op($urandom_range(0, 7)), $urandom_range(0, 2),
             $urandom_range(0, tmo + 1), ($urandom_range(0, 3) == 0), 1'b0);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      tag = 0;
      sel = 1'b0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      op = '0;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      irq = 1'b0;
      @(posedge clk);
      #1;
      step('0);
      step('0);
      rst_a = 1'b1;
      tag = 1;  run(11'b10001011000, 0, 0, 1'b0, 1'b0);
      tag = 2;  run(11'b11111000010, 1, 3, 1'b0, 1'b0);
      tag = 3;  run(11'b11111000000, 0, 99, 1'b0, 1'b0);
      tag = 4;  run(11'b00000000000, 0, 0, 1'b0, 1'b0);
      tag = 5;  run(11'b10001011000, 0, 0, 1'b1, 1'b0);
      tag = 6;  run(11'b10110100101, 2, 0, 1'b0, 1'b0);
      tag = 7;  run(11'b11010110100, 0, 0, 1'b0, 1'b0);
      tag = 8;  run(11'b11010101001, 0, 0, 1'b0, 1'b0);
      tag = 9;  run(11'b11010110000, 1, 0, 1'b0, 1'b0);
      tag = 10; run(11'b11111000000, 0, TMO_A - 1, 1'b0, 1'b0);
      tag = 11; run(11'b11111000010, 0, TMO_A, 1'b0, 1'b0);
      rand_runs(200);
      tag = 500;
      run(11'b11111000010, 0, 99, 1'b0, 1'b1);
      dmem_ready = 1'b0;
      #2;
      rst_a = 1'b0;
      #1;
      n_cmp++;
      if (obs !== '0) begin
         n_bad++;
         $display("FAIL async_reset got=%h exp=0", obs);
      end
      step('0);
      step('0);
      rst_a = 1'b1;
      tag = 501; run(11'b10001011000, 0, 0, 1'b0, 1'b0);
      rst_a = 1'b0;
      sel = 1'b1;
      rst_b = 1'b1;
      tag = 600; run(11'b11111000010, 1, 2, 1'b1, 1'b0);
      tag = 601; run(11'b11111000000, 0, TMO_B - 1, 1'b0, 1'b0);
      tag = 602; run(11'b11111000010, 0, TMO_B, 1'b0, 1'b0);
      tag = 700;
      rand_runs(100);
      repeat (2) @(negedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
